// File: rtl/mem_ctrl_if.sv
// Request / write-data / read-data / RAM-port bundle for mem_ctrl.
// slave is the controller's view; master is the CPU-datapath plus RAM side.
interface mem_ctrl_if #(
  parameter int MAX_LEN_W = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [7:0]           req_addr;
  logic [MAX_LEN_W-1:0] req_len;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [31:0]          wr_data;

  logic                 rd_valid;
  logic [31:0]          rd_data;

  logic                 busy;
  logic                 done;

  logic [7:0]           mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_we;
  logic                 mem_re;
  logic [31:0]          mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wr_valid, wr_data,
    output mem_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_valid, wr_data,
    input  mem_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done,
    output mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single/burst load-store sequencer for the 8-bit-address, 32-bit-data sync RAM port.
// Define MEM_CTRL_BURST_EN to honour req_len; otherwise every transfer is one word.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   S_IDLE     | waiting for a request, req_ready high
//   S_RD       | issuing read strobes, one address per cycle
//   S_RD_DRAIN | two cycles for RAM latency + rd_data register
//   S_WR       | accepting write words, one RAM write per accepted word
//   S_WR_LAST  | last write strobe on the RAM port
//   S_DONE     | done pulse, back to idle
module mem_ctrl #(
  parameter int MAX_LEN_W = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  mem_ctrl_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DRAIN,
    S_WR,
    S_WR_LAST,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  addr_q;
  logic [7:0]  mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic        re_d1;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        done_q;
  logic        drain_cnt;
  logic        last_word;

`ifdef MEM_CTRL_BURST_EN
  // Remaining words after the one currently being issued/accepted.
  logic [MAX_LEN_W-1:0] cnt;
  logic                 accept;
  logic                 wr_take;

  assign accept  = bus.req_valid && (state == S_IDLE);
  assign wr_take = bus.wr_valid && (state == S_WR);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= bus.req_len;
    end else if (((state == S_RD) || wr_take) && (cnt != '0)) begin
      cnt <= cnt - MAX_LEN_W'(1);
    end
  end

  assign last_word = (cnt == '0);
`else
  logic unused_req_len;

  assign unused_req_len = ^bus.req_len;
  assign last_word      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = bus.req_write ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (last_word) begin
          state_nxt = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (drain_cnt == 1'b0) begin
          state_nxt = S_DONE;
        end
      end
      S_WR: begin
        if (bus.wr_valid && last_word) begin
          state_nxt = S_WR_LAST;
        end
      end
      S_WR_LAST: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.wr_ready  = (state == S_WR);
    bus.busy      = (state != S_IDLE);
  end

  // RAM strobes, read-return pipeline and done pulse, all registered.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      addr_q      <= 8'h00;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      re_d1       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 32'h0;
      done_q      <= 1'b0;
      drain_cnt   <= 1'b0;
    end else begin
      re_d1      <= mem_re_q;
      rd_valid_q <= re_d1;
      if (re_d1) begin
        rd_data_q <= bus.mem_rdata;
      end
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_write) begin
              addr_q <= bus.req_addr;
            end else begin
              // First read strobe goes out with the accept edge.
              mem_re_q   <= 1'b1;
              mem_addr_q <= bus.req_addr;
              addr_q     <= bus.req_addr + 8'd1;
            end
          end
        end
        S_RD: begin
          if (!last_word) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= addr_q;
            addr_q     <= addr_q + 8'd1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_RD_DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_WR: begin
          if (bus.wr_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.wr_data;
            addr_q      <= addr_q + 8'd1;
          end
        end
        S_WR_LAST: begin
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed table of transfers, then random transfers, each checked
// cycle by cycle against the documented timing and a word-array model of the RAM contents.
module tb_mem_ctrl;

`ifdef MEM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  mem_ctrl_if #(.MAX_LEN_W(4)) bus ();

  mem_ctrl #(.MAX_LEN_W(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // RAM with one-cycle read latency, written by the DUT's strobes.
  logic [31:0] ram [256] = '{default: 32'h0};
  logic [31:0] rdata_q = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  logic [31:0] ref_mem [256] = '{default: 32'h0};
  logic [31:0] exp_rd_hold = 32'h0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [31:0] data;
    int          stall_after;
    int          stall_len;
    int          rst_at;
    int          exp_done;
  } vec_t;

  vec_t tbl [9];

  function automatic int eff_len(input logic [3:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                              input logic [31:0] data, input int sa, input int sl, input int ra);
    vec_t v;
    int   l;
    l = eff_len(len);
    v.wr = wr; v.addr = addr; v.len = len; v.data = data;
    v.stall_after = sa; v.stall_len = sl; v.rst_at = ra;
    if (wr)                v.exp_done = l + 2 + ((sa < l) ? sl : 0);
    else if (ra > 0)       v.exp_done = (l + 3 < ra) ? l + 3 : -1;
    else                   v.exp_done = l + 3;
    return v;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int k, input logic e_rdy, input logic e_wrdy, input logic e_busy,
                             input logic e_done, input logic e_re, input logic e_we, input logic e_rv,
                             input logic [7:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    @(negedge clk);
    chk("req_ready", k, 32'(bus.req_ready), 32'(e_rdy));
    chk("wr_ready",  k, 32'(bus.wr_ready),  32'(e_wrdy));
    chk("busy",      k, 32'(bus.busy),      32'(e_busy));
    chk("done",      k, 32'(bus.done),      32'(e_done));
    chk("mem_re",    k, 32'(bus.mem_re),    32'(e_re));
    chk("mem_we",    k, 32'(bus.mem_we),    32'(e_we));
    chk("rd_valid",  k, 32'(bus.rd_valid),  32'(e_rv));
    chk("rd_data",   k, bus.rd_data, e_rdata);
    if (e_re || e_we) chk("mem_addr", k, 32'(bus.mem_addr), 32'(e_addr));
    if (e_we)         chk("mem_wdata", k, bus.mem_wdata, e_wdata);
  endtask

  task automatic drive_noise_req();
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = 8'($urandom);
    bus.req_len   = 4'($urandom);
  endtask

  task automatic do_load(input logic [7:0] addr, input logic [3:0] len, input int rst_at,
                         output int done_cyc);
    int   l;
    int   k_end;
    logic e_rv;
    l = eff_len(len);
    done_cyc = -1;
    next_cycle();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = addr; bus.req_len = len;
    bus.wr_valid = 1'($urandom_range(0, 1)); bus.wr_data = $urandom;
    @(negedge clk);
    chk("accept_ready", 0, 32'(bus.req_ready), 32'h1);
    k_end = (rst_at > 0) ? rst_at : l + 4;
    for (int k = 1; k <= k_end; k++) begin
      next_cycle();
      if (k >= k_end) bus.req_valid = 1'b0;
      else            drive_noise_req();
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data  = $urandom;
      if (k == rst_at) clr_n = 1'b0;
      e_rv = (k >= 3) && (k <= l + 2);
      if (e_rv) exp_rd_hold = ref_mem[8'(int'(addr) + k - 3)];
      check_cycle(k, k == l + 4, 1'b0, k <= l + 3, k == l + 3, k <= l, 1'b0, e_rv,
                  8'(int'(addr) + k - 1), 32'h0, exp_rd_hold);
      if (bus.done) done_cyc = k;
    end
    if (rst_at > 0) begin
      next_cycle();
      exp_rd_hold = 32'h0;
      check_cycle(rst_at + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      chk("rst_mem_addr",  rst_at + 1, 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", rst_at + 1, bus.mem_wdata, 32'h0);
      clr_n = 1'b1;
      for (int k = rst_at + 2; k <= rst_at + 4; k++) begin
        next_cycle();
        check_cycle(k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        if (bus.done) done_cyc = k;
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_store(input logic [7:0] addr, input logic [3:0] len, input int stall_after,
                          input int stall_len, input bit rnd, input logic [31:0] first_data,
                          output int done_cyc);
    int          l;
    int          acc;
    int          k_last;
    int          stall_left;
    bit          fin;
    bit          v;
    bit          exp_wrdy;
    bit          pend_we;
    logic [7:0]  pend_addr;
    logic [31:0] pend_data;
    l = eff_len(len);
    acc = 0; k_last = -1; stall_left = stall_len; fin = 1'b0;
    pend_we = 1'b0; pend_addr = 8'h00; pend_data = 32'h0;
    done_cyc = -1;
    next_cycle();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = addr; bus.req_len = len;
    bus.wr_valid = 1'($urandom_range(0, 1)); bus.wr_data = $urandom;
    @(negedge clk);
    chk("accept_ready", 0, 32'(bus.req_ready), 32'h1);
    for (int k = 1; k <= 200; k++) begin
      next_cycle();
      exp_wrdy = (k_last < 0);
      if (k_last >= 0 && k == k_last + 3) bus.req_valid = 1'b0;
      else                                drive_noise_req();
      if (!exp_wrdy)       v = 1'($urandom_range(0, 1));
      else if (rnd)        v = (k > 40) || ($urandom_range(0, 3) != 0);
      else if (acc == stall_after && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else             v = 1'b1;
      bus.wr_valid = v;
      if (exp_wrdy && v) bus.wr_data = rnd ? $urandom : first_data + 32'(acc);
      else               bus.wr_data = $urandom;
      check_cycle(k, k_last >= 0 && k == k_last + 3, exp_wrdy, !(k_last >= 0 && k == k_last + 3),
                  k_last >= 0 && k == k_last + 2, 1'b0, pend_we, 1'b0, pend_addr, pend_data, exp_rd_hold);
      if (bus.done) done_cyc = k;
      if (k_last >= 0 && k == k_last + 3) begin
        fin = 1'b1;
        break;
      end
      if (exp_wrdy && v) begin
        pend_we   = 1'b1;
        pend_addr = 8'(int'(addr) + acc);
        pend_data = bus.wr_data;
        ref_mem[pend_addr] = pend_data;
        acc++;
        if (acc == l) k_last = k;
      end else begin
        pend_we = 1'b0;
      end
    end
    if (!fin) chk("store_timeout", 200, 32'h0, 32'h1);
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dc;
    tbl[0] = mk(1'b1, 8'h10, 4'd0,  32'hDEADBEEF, 0, 0, 0);
    tbl[1] = mk(1'b0, 8'h10, 4'd0,  32'h0,        0, 0, 0);
    tbl[2] = mk(1'b1, 8'hFE, 4'd3,  32'h1,        0, 0, 0);
    tbl[3] = mk(1'b0, 8'hFE, 4'd3,  32'h0,        0, 0, 0);
    tbl[4] = mk(1'b1, 8'h40, 4'd2,  32'hA0,       1, 2, 0);
    tbl[5] = mk(1'b0, 8'h40, 4'd2,  32'h0,        0, 0, 0);
    tbl[6] = mk(1'b0, 8'h20, 4'd15, 32'h0,        0, 0, 5);
    tbl[7] = mk(1'b0, 8'hFE, 4'd3,  32'h0,        0, 0, 0);
    tbl[8] = mk(1'b0, 8'h10, 4'd7,  32'h0,        0, 0, 0);

    clr_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h55; bus.req_len = 4'h3;
    bus.wr_valid = 1'b1; bus.wr_data = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      check_cycle(-2 + i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      chk("rst_mem_addr",  -2 + i, 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", -2 + i, bus.mem_wdata, 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    clr_n = 1'b1;
    next_cycle();
    check_cycle(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) do_store(tbl[i].addr, tbl[i].len, tbl[i].stall_after, tbl[i].stall_len,
                              1'b0, tbl[i].data, dc);
      else           do_load(tbl[i].addr, tbl[i].len, tbl[i].rst_at, dc);
      chk("done_cycle", i, 32'(dc), 32'(tbl[i].exp_done));
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [3:0] n;
      a = 8'($urandom_range(0, 31)) + 8'hF0;
      n = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, n, 0, 0, 1'b1, 32'h0, dc);
        chk("rand_store_done_seen", i, 32'(dc > 0), 32'h1);
      end else begin
        do_load(a, n, 0, dc);
        chk("rand_load_done_cycle", i, 32'(dc), 32'(eff_len(n) + 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Bus-initiator block that drives the 8-bit-address, 32-bit-data synchronous RAM port (`address`, `RAM_data_in`, `RAM_data_out`, `write_enable`, `read_enable`) on behalf of the CPU datapath. It accepts single or burst load/store requests over a valid/ready handshake, sequences the RAM control strobes, streams read data back with a valid pulse, and accepts write data word-by-word. It sits between the datapath's MAR/MDR logic and the RAM instance.

## Interface
Parameters:
- `MAX_LEN_W`, 4, width of `req_len`; a burst is `req_len + 1` words, 1..16.

Ports:
- `clk` in 1: the single clock, rising edge.
- `clr_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted. High only in IDLE.
- `req_write` in 1: 1 selects store, 0 selects load. Sampled at accept.
- `req_addr` in 8: start word address. Sampled at accept.
- `req_len` in `MAX_LEN_W`: word count minus one. Sampled at accept.
- `wr_valid` in 1: write word present on `wr_data`.
- `wr_ready` out 1: write word consumed when high together with `wr_valid`.
- `wr_data` in 32: store data.
- `rd_valid` out 1: one-cycle pulse per returned load word. There is no backpressure.
- `rd_data` out 32: load data. Holds its last value when `rd_valid` is low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of each transfer.
- `mem_addr` out 8: goes to the RAM `address` input.
- `mem_wdata` out 32: goes to the RAM `RAM_data_in` input.
- `mem_we` out 1: goes to the RAM `write_enable` input.
- `mem_re` out 1: goes to the RAM `read_enable` input.
- `mem_rdata` in 32: comes from the RAM `RAM_data_out` output.

## Operation
FSM states and transitions:
- IDLE → RD when `req_valid`=1 and `req_write`=0.
- IDLE → WR when `req_valid`=1 and `req_write`=1.
- RD → RD_DRAIN after issuing L = `req_len`+1 read strobes.
- RD_DRAIN → DONE after 2 cycles.
- WR → WR_LAST after the L-th word is accepted.
- WR_LAST → DONE.
- DONE → IDLE.

Signal behaviour:
- Accept occurs on a rising edge with `req_valid`=1 and `req_ready`=1. At accept, the block latches the address, the remaining count and the direction.
- All `mem_*`, `rd_*` and `done` outputs are registered. `req_ready`, `wr_ready` and `busy` are decoded from state.
- RD: `mem_re`=1 on every cycle, with `mem_addr` = start + i for i = 0..L-1. The RAM has 1-cycle read latency.
  - `mem_rdata` is registered into `rd_data` one cycle after it becomes valid.
  - `rd_valid` pulses once per word, in address order, on consecutive cycles.
- WR: `wr_ready`=1 while accepted words < L.
  - Each accepted word produces `mem_we`=1, `mem_addr` = start + i and `mem_wdata` = word in the following cycle.
  - While `wr_valid`=0, `mem_we`=0. The address and count do not advance.
- Address arithmetic is 8-bit modulo 256: 0xFF + 1 wraps to 0x00.
- `mem_re` and `mem_we` are never high in the same cycle.
- Reset values (forced whenever `clr_n`=0 at an edge): state IDLE; `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `rd_data`=0, `rd_valid`=0, `done`=0, internal counters 0.
- Reset mid-transfer abandons the transfer with no `done`. A write strobe already presented before the reset edge completes in the RAM.
- `req_valid` outside IDLE is ignored.
- `wr_valid` outside WR is ignored, because `wr_ready`=0.

## Timing
Cycle 0 is the accept cycle.
- Load of L words:
  - `mem_re` is high in cycles 1..L.
  - `rd_valid` is high in cycles 3..L+2. The word for address start + i appears in cycle 3+i.
  - `done` is high in cycle L+3.
  - `req_ready` is high again in cycle L+4.
- Store of L words, with `wr_valid` held high:
  - `wr_ready` is high in cycles 1..L.
  - `mem_we` is high in cycles 2..L+1.
  - `done` is high in cycle L+2.
  - `req_ready` is high in cycle L+3.
  - Each stall cycle on `wr_valid` shifts all later events by 1.
- Minimum request-to-request spacing: L+4 cycles for a load, L+3 cycles for a store.

## Configuration
- `MEM_CTRL_BURST_EN` defined: `req_len` is honoured, giving bursts of 1..2^`MAX_LEN_W` words.
- `MEM_CTRL_BURST_EN` undefined:
  - `req_len` is ignored and every transfer is 1 word.
  - The remaining-count logic is removed.
  - Timing matches L=1.

## Test plan
- Reset: hold `clr_n`=0 for 2 cycles with `req_valid`=1 → all outputs 0, `req_ready`=1 after release, no RAM strobes.
- Single store, then single load: store 0xDEADBEEF to addr 0x10, then load addr 0x10 → `mem_we` in cycle 2, `done` in cycle 3; `rd_valid` in cycle 3 with `rd_data`=0xDEADBEEF, `done` in cycle 4.
- Burst wrap: store 4 words 0x1..0x4 at addr 0xFE, then load 4 words at 0xFE → `mem_addr` sequence FE, FF, 00, 01; `rd_data` sequence 1, 2, 3, 4 on 4 consecutive cycles.
- Write stall: 3-word store with `wr_valid` low for 2 cycles after word 1 → `mem_we` gaps of 2 cycles, no address skip, `done` in cycle 7.
- Mid-burst reset: 16-word load, assert `clr_n`=0 in cycle 5 → outputs 0 on the next edge, no `done`, next request serviced normally.
- Without `MEM_CTRL_BURST_EN`: load with `req_len`=7 → exactly 1 `rd_valid`, `done` in cycle 4.
